reg_file_bank: RTL
==================

// Module: reg_file_bank
// PURPOSE
//   Parametrised multi-read-port register file for the datapath: NREG x W storage,
//   NRD registered read ports with write-to-read bypass, one write port, and a PC alias
//   (reads of PC_IDX return the external R15 value).
//   Adds a handshaked clear sequencer that zeroes the file one entry per cycle.
//   Sits between decode (addresses) and execute (operands); writeback drives A3/WD3/WE3.
// PARAMETERS
//   W       32  data width in bits
//   NREG    16  number of registers (power of 2, >=4)
//   AW      4   address width; must equal clog2(NREG)
//   NRD     2   number of read ports (1..4)
//   PC_IDX  15  index aliased to input R15; never written internally
// PORTS
//   CLK       in   1       clock; all state changes on posedge
//   RST_N     in   1       synchronous reset, active-low
//   RA        in   NRD*AW  read addresses; port i = RA[i*AW +: AW]
//   RD        out  NRD*W   read data; port i = RD[i*W +: W]; registered
//   A3        in   AW      write address
//   WD3       in   W       write data
//   WE3       in   1       write enable
//   R15       in   W       PC value returned for reads of PC_IDX
//   CLR_REQ   in   1       request to clear the whole file (level, sampled at posedge)
//   CLR_BUSY  out  1       high while a clear is in progress
//   CLR_DONE  out  1       one-cycle pulse when the clear has completed
//   PAR_ERR   out  1       sticky parity error flag (0 when parity is compiled out)
// BEHAVIOUR
//   Reset (RST_N=0 at posedge): all registers, all RD and PAR_ERR go to 0.
//     CLR_BUSY=0, CLR_DONE=0, FSM=IDLE. Reset overrides any write, read or clear in the same cycle.
//   Write: at posedge, if WE3 && !CLR_BUSY && A3!=PC_IDX, then regs[A3]<=WD3.
//     Writes to PC_IDX are silently dropped.
//   Read latency is 1 cycle. At each posedge, for every port i:
//     RA_i==PC_IDX -> R15 (sampled this edge)
//     else a write is accepted this edge with A3==RA_i -> WD3 (bypass)
//     else -> regs[RA_i]
//   Ports are independent; the same address on several ports returns the same data.
//   Clear FSM, 3 states:
//     IDLE  -> SWEEP on CLR_REQ=1; cnt<=0.
//     SWEEP: regs[cnt]<=0 each cycle; cnt++. CLR_BUSY=1. WE3 is ignored (not queued).
//            After cnt==NREG-1 is written -> DONE.
//     DONE:  CLR_DONE=1 for exactly one cycle -> IDLE. CLR_BUSY=0 in DONE.
//   Clear timing: NREG cycles of CLR_BUSY, then the DONE pulse. CLR_REQ is ignored
//     outside IDLE; if still high in IDLE after DONE, a new sweep starts.
//   Reads during SWEEP are legal and return array contents (no bypass of clear zeros).
//   Reset mid-sweep aborts to IDLE with all registers 0; no CLR_DONE pulse.
//   cnt is AW bits wide; it wraps only after the final entry, so the wrap is never observable.
// CONFIGURATION
//   REGFILE_PARITY_EN defined:
//     - Each entry stores an extra even-parity bit (^data) on every write and clear.
//     - Every read port whose RA!=PC_IDX recomputes parity. A mismatch sets PAR_ERR
//       at the same edge RD updates.
//     - PAR_ERR is sticky until reset.
//   REGFILE_PARITY_EN undefined: no parity storage; PAR_ERR is tied to 0; the port is kept.
// STRUCTURE
//   Package regfile_pkg:
//     - clr_state_t enum {CLR_IDLE, CLR_SWEEP, CLR_DONE}
//     - default constants for W, NREG, PC_IDX
//     - function clog2
//   Sub-module regfile_clr_seq: FSM + sweep counter.
//     Outputs clr_we, clr_addr, CLR_BUSY, CLR_DONE. The top muxes clr_addr/0 onto the write path.
//   Storage and read ports are a generate loop over NRD in reg_file_bank.
// TESTING
//   1. Reset, write A3=3 WD3=0xDEADBEEF, next cycle RA0=3 -> RD0=0xDEADBEEF one cycle later;
//      RD1 (RA1=4) = 0.
//   2. Same-cycle WE3 A3=5 WD3=0x1234 with RA1=5 -> RD1=0x1234 at that edge (bypass).
//   3. R15=0x00000108, RA0=15, WE3 A3=15 WD3=0xFFFF -> RD0=0x108; a later read of 15 with
//      R15=0 returns 0.
//   4. Fill all regs with 0xA5A5A5A5, pulse CLR_REQ -> CLR_BUSY high 16 cycles then CLR_DONE
//      for 1 cycle. WE3 during the sweep is dropped; all reads then return 0.
//   5. Assert RST_N=0 at sweep cycle 7 -> CLR_BUSY=0 the next cycle, no CLR_DONE, all RD=0.
//   6. (PARITY_EN) Force-flip one stored bit of reg 2, read RA0=2 -> PAR_ERR=1, stays 1
//      until RST_N=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file bank.
//   clr_state_t : clear sequencer states
//   DEF_*       : default geometry (W, NREG, PC_IDX)
//   clog2       : address width helper for parameter defaults
package regfile_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  localparam int DEF_W      = 32;
  localparam int DEF_NREG   = 16;
  localparam int DEF_PC_IDX = 15;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every entry of the register file once, one per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_req    : level request, honoured only in CLR_IDLE
//   clr_we     : write strobe for the zeroing write
//   clr_addr   : entry being zeroed this cycle
//   clr_busy   : high for the NREG sweep cycles
//   clr_done   : one-cycle pulse after the last entry has been zeroed
//
// state     | meaning
// CLR_IDLE  | waiting for clr_req
// CLR_SWEEP | zeroing entry cnt, cnt advances every cycle
// CLR_DONE  | sweep finished, clr_done pulse
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    case (state)
      CLR_IDLE: begin
        if (clr_req) begin
          state_nxt = CLR_SWEEP;
          cnt_nxt   = '0;
        end
      end
      CLR_SWEEP: begin
        clr_we   = 1'b1;
        clr_busy = 1'b1;
        // cnt wraps to 0 right after the last entry; the FSM has already left SWEEP
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST) state_nxt = CLR_DONE;
      end
      CLR_DONE: begin
        clr_done  = 1'b1;
        state_nxt = CLR_IDLE;
      end
      default: state_nxt = CLR_IDLE;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_bank.sv
// Multi-read-port register file with write bypass, PC alias and clear sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   ra         : NRD read addresses, port i at ra[i*AW +: AW]
//   rd         : NRD registered read data, port i at rd[i*W +: W]
//   a3/wd3/we3 : write port (writes to PC_IDX and during a clear are dropped)
//   r15        : value returned for reads of PC_IDX
//   clr_req    : start a full clear; clr_busy/clr_done report progress
//   par_err    : sticky parity error
// Optional feature macro: REGFILE_PARITY_EN (per-entry even parity and
// read-side check). Without it par_err is tied to 0.
module reg_file_bank
  import regfile_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int NREG   = DEF_NREG,
  parameter int AW     = clog2(NREG),
  parameter int NRD    = 2,
  parameter int PC_IDX = DEF_PC_IDX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*W-1:0]  rd,
  input  logic [AW-1:0]     a3,
  input  logic [W-1:0]      wd3,
  input  logic              we3,
  input  logic [W-1:0]      r15,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              par_err
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          host_we;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  regs [NREG];

  regfile_clr_seq #(.NREG(NREG), .AW(AW)) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  // host writes are dropped (not deferred) while the sweep owns the write path
  assign host_we = we3 && !clr_busy && (a3 != PC_A);
  assign wr_en   = clr_we || host_we;
  assign wr_addr = clr_we ? clr_addr : a3;
  assign wr_data = clr_we ? '0 : wd3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic           par [NREG];
  logic [NRD-1:0] rd_perr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) par[i] <= 1'b0;
    end else if (wr_en) begin
      par[wr_addr] <= ^wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        par_err <= 1'b0;
    else if (|rd_perr) par_err <= 1'b1;
  end
`else
  assign par_err = 1'b0;
`endif

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] ra_i;
    logic [W-1:0]  rd_q;

    assign ra_i = ra[g*AW +: AW];

    always_ff @(posedge clk) begin
      if (!rst_n)                       rd_q <= '0;
      else if (ra_i == PC_A)            rd_q <= r15;
      else if (host_we && a3 == ra_i)   rd_q <= wd3;
      else                              rd_q <= regs[ra_i];
    end

`ifdef REGFILE_PARITY_EN
    // bypassed and PC reads never touch the array, so they cannot flag an error
    assign rd_perr[g] = (ra_i != PC_A) && !(host_we && a3 == ra_i) &&
                        ((^regs[ra_i]) != par[ra_i]);
`endif

    assign rd[g*W +: W] = rd_q;
  end

endmodule
